// File: rtl/inst_sram_resp.sv
// Instruction SRAM with zero-fill, byte-stream loader and a registered, read-first request port.
// Request-port byte writes exist only when INST_SRAM_WRITE_EN is defined.
module inst_sram_resp #(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        mem_ready,
    output logic        load_err,
    output logic        req_err
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_WORD = {ADDR_W{1'b1}};
    localparam logic [32:0]     WINDOW    = 33'd4 << ADDR_W;

    typedef enum logic [1:0] {CLEAR, LOAD, READY} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   counter, counter_next;
    logic [1:0]          byte_idx, byte_idx_next;
    logic [31:0]         word_buf, word_buf_next;
    logic                load_err_next;
    logic [31:0]         cur_word;
    logic                fill_we;
    logic [31:0]         fill_data;

    logic [31:0]         mem [DEPTH];

    logic [31:0]         offset;
    logic                hit;
    logic                req_ok;
    logic [ADDR_W-1:0]   index;

    assign offset    = inst_sram_addr - BASE;
    assign hit       = ({1'b0, offset} < WINDOW);
    assign index     = offset[ADDR_W+1:2];
    assign req_ok    = inst_sram_en && (state == READY) && hit;
    assign ld_ready  = (state == LOAD);
    assign mem_ready = (state == READY);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= CLEAR;
            counter  <= '0;
            byte_idx <= 2'd0;
            word_buf <= 32'h0;
            load_err <= 1'b0;
        end else begin
            state    <= state_next;
            counter  <= counter_next;
            byte_idx <= byte_idx_next;
            word_buf <= word_buf_next;
            load_err <= load_err_next;
        end
    end

    // The buffer is zeroed after every word write so a short final word pads with zeros.
    always_comb begin
        state_next    = state;
        counter_next  = counter;
        byte_idx_next = byte_idx;
        word_buf_next = word_buf;
        load_err_next = load_err;
        fill_we       = 1'b0;
        fill_data     = 32'h0;
        cur_word      = word_buf;
        cur_word[{byte_idx, 3'b000} +: 8] = ld_data;
        case (state)
            CLEAR: begin
                fill_we = 1'b1;
                if (counter == LAST_WORD) begin
                    state_next   = LOAD;
                    counter_next = '0;
                end else begin
                    counter_next = counter + 1'b1;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    if (ld_last || (byte_idx == 2'd3)) begin
                        fill_we       = 1'b1;
                        fill_data     = cur_word;
                        word_buf_next = 32'h0;
                        byte_idx_next = 2'd0;
                        if (ld_last) begin
                            state_next = READY;
                        end else if (counter == LAST_WORD) begin
                            load_err_next = 1'b1;
                            state_next    = READY;
                        end else begin
                            counter_next = counter + 1'b1;
                        end
                    end else begin
                        word_buf_next = cur_word;
                        byte_idx_next = byte_idx + 2'd1;
                    end
                end
            end
            READY: begin
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_sram_rdata <= 32'h0;
            req_err         <= 1'b0;
        end else if (inst_sram_en) begin
            if (req_ok) begin
                inst_sram_rdata <= mem[index];
            end else begin
                inst_sram_rdata <= 32'h0;
                req_err         <= 1'b1;
            end
        end
    end

    // Fill writes happen only in CLEAR/LOAD and request writes only in READY, so they never collide.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[counter] <= fill_data;
        end
`ifdef INST_SRAM_WRITE_EN
        else if (req_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (inst_sram_wen[i]) begin
                    mem[index][i*8 +: 8] <= inst_sram_wdata[i*8 +: 8];
                end
            end
        end
`endif
    end

`ifdef INST_SRAM_WRITE_EN
    logic unused_bits;
    assign unused_bits = ^offset[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{offset[1:0], inst_sram_wen, inst_sram_wdata};
`endif

endmodule

// File: doc/inst_sram_resp.md
INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; capacity 2^ADDR_W 32-bit words.
REQ-002 Parameter BASE, default 32'hbfc00000, byte address of word 0.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 inst_sram_en  input  1  access request this cycle.
REQ-006 inst_sram_wen  input  4  byte write enables; 4'h0 means read.
REQ-007 inst_sram_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 inst_sram_wdata  input  32  write data.
REQ-009 inst_sram_rdata  output  32  registered read data.
REQ-010 ld_valid  input  1  loader byte valid.
REQ-011 ld_data  input  8  loader byte.
REQ-012 ld_last  input  1  marks final loader byte; sampled with ld_valid.
REQ-013 ld_ready  output  1  loader byte accepted when ld_valid && ld_ready.
REQ-014 mem_ready  output  1  high only in READY state.
REQ-015 load_err  output  1  sticky: loader image overflowed capacity.
REQ-016 req_err  output  1  sticky: request made out of window or while not READY.

Function
REQ-017 FSM states CLEAR, LOAD, READY; reset enters CLEAR with word counter 0.
REQ-018 CLEAR: write 32'h0 to word[counter], counter+1 per cycle; after word 2^ADDR_W-1 go LOAD, counter 0.
REQ-019 LOAD: ld_ready=1; other states ld_ready=0.
REQ-020 LOAD: accepted bytes packed little-endian (1st byte -> [7:0]) into a word buffer; 4th byte writes word[counter], counter+1, byte index to 0.
REQ-021 ld_last on accepted byte: write current word (unfilled bytes 0), go READY next cycle.
REQ-022 A full-word write at counter 2^ADDR_W-1 without ld_last: set load_err, go READY; no wrap.
REQ-023 Window hit: (addr - BASE) < 4*2^ADDR_W, 32-bit unsigned; word index = (addr-BASE)[ADDR_W+1:2].
REQ-024 READY, en=1, wen=0, hit: rdata <= word[index] at next posedge (latency 1).
REQ-025 en=0: rdata holds previous value.
REQ-026 en=1 with miss, or en=1 in CLEAR/LOAD: rdata <= 0, req_err <= 1, memory unchanged.
REQ-027 en=1 with wen!=0 in READY, hit: behaviour per REQ-033/034; rdata returns pre-write word (read-first).
REQ-028 Back-to-back requests every cycle supported; no stall output exists.

Reset
REQ-029 resetn low: state CLEAR, counter 0, byte index 0, rdata 32'h0, load_err 0, req_err 0, mem_ready 0, ld_ready 0.
REQ-030 resetn asserted mid-LOAD or mid-READY: immediate abort; full CLEAR/LOAD sequence restarts after release; partial words discarded.
REQ-031 Memory array not reset; CLEAR defines contents.
REQ-032 Sticky flags clear only on reset.

Configuration
REQ-033 INST_SRAM_WRITE_EN defined: READY hit with wen!=0 writes each byte lane i where wen[i]=1 from wdata.
REQ-034 INST_SRAM_WRITE_EN undefined: wen ignored; every access is a read; no write logic to the array from the request port.

Verification
REQ-035 ADDR_W=4: release reset; mem_ready rises after exactly 16 CLEAR cycles plus load; read BASE+4 before any load data -> rdata 0 and req_err 1.
REQ-036 Load bytes 13,00,80,3c,ld_last on 5th byte 0xAA; read BASE -> 32'h3c800013, BASE+4 -> 32'h000000AA, one cycle after en.
REQ-037 Read addr 32'hbfc00040 with ADDR_W=4 -> rdata 0, req_err 1; BASE+0x3c valid, no error.
REQ-038 Load 68 bytes without ld_last, ADDR_W=4 -> load_err 1 after 64th byte, mem_ready 1, 65th byte not accepted.
REQ-039 With INST_SRAM_WRITE_EN: word0=32'h11223344, wen=4'b0101, wdata=32'hAABBCCDD -> that cycle's rdata 32'h11223344, next read 32'h11BB33DD; without macro -> 32'h11223344.
REQ-040 Pull resetn low during LOAD after 6 bytes -> all outputs to reset values asynchronously; after release CLEAR repeats, reads return 0 until reloaded.
